decrypt_ctrl: RTL and testbench
===============================

DECRYPT_CTRL -- requirements
Module: decrypt_ctrl

Interface
REQ-001 SHALL have parameter PLAINTEXT_WIDTH, default 6, plaintext result width.
REQ-002 SHALL have parameter CIPHERTEXT_WIDTH, default 10, key/ciphertext entry width.
REQ-003 SHALL have parameter DIMENSION, default 10, LWE dimension n; a ciphertext is n+1 entries.
REQ-004 SHALL have parameter PARALLEL, default 1, entries consumed per beat.
REQ-005 SHALL have parameter ADDR_WIDTH, default 8, memory word-address width.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports start (input, 1) and ct_base (input, ADDR_WIDTH): request and ciphertext base word address.
REQ-009 SHALL have port busy, output, 1: high whenever not IDLE.
REQ-010 SHALL have ports sk_addr and ct_addr (outputs, ADDR_WIDTH): memory read addresses, one PARALLEL-wide word per address.
REQ-011 SHALL have ports sk_rd and ct_rd, outputs, 1: read strobes.
REQ-012 SHALL have ports sk_rdata and ct_rdata, inputs, PARALLEL x CIPHERTEXT_WIDTH: read data, valid exactly one cycle after strobe.
REQ-013 SHALL have ports result_valid (output, 1), result_ready (input, 1), result (output, PLAINTEXT_WIDTH).

Function
REQ-014 SHALL compute BEATS = ceil((DIMENSION+1)/PARALLEL); entries beyond DIMENSION in the last beat are zeroed before the datapath.
REQ-015 SHALL implement states IDLE, FETCH, DRAIN, HOLD.
REQ-016 IDLE: start=1 latches ct_base and moves to FETCH; start ignored in every other state.
REQ-017 FETCH: each cycle asserts sk_rd/ct_rd with sk_addr=k, ct_addr=ct_base+k, k=0..BEATS-1; after k=BEATS-1 moves to DRAIN.
REQ-018 Datapath enable SHALL be the read strobe delayed one cycle; row presented = k of that read; row 0 restarts the accumulator.
REQ-019 DRAIN: lasts exactly 2 cycles (last beat accumulates, then result settles); at exit captures result and moves to HOLD.
REQ-020 HOLD: result_valid=1, result stable; result_valid&result_ready moves to IDLE next cycle.
REQ-021 Latency start to first result_valid SHALL be BEATS+3 cycles.
REQ-022 Dot product SHALL accumulate mod 2^(2*CIPHERTEXT_WIDTH+1); result = low PLAINTEXT_WIDTH bits.
REQ-023 ct_base+k SHALL wrap modulo 2^ADDR_WIDTH.
REQ-024 start coincident with result_ready in HOLD SHALL be ignored; a new request is accepted only in IDLE.
REQ-025 Read strobes SHALL be 0 outside FETCH.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, busy=0, result_valid=0, result=0, strobes=0, addresses=0, beat counter=0, accumulator=0.
REQ-027 Reset mid-FETCH/DRAIN SHALL discard the operation; no result_valid produced afterward.

Configuration
REQ-028 Macro DECRYPT_CTRL_ABORT_EN SHALL add input abort (1 bit): in FETCH or DRAIN it returns to IDLE next cycle, drops strobes, no result_valid.
REQ-029 Without DECRYPT_CTRL_ABORT_EN the abort port SHALL not exist and every operation runs to HOLD.

Structure
REQ-030 Shared package enclave_pkg SHALL hold the state enum and the BEATS computation function.
REQ-031 SHALL instantiate exactly one sub-module, decrypt (dot-product datapath), driven with en/row/entries per REQ-018.

Verification
REQ-032 Defaults, sk all 1, ct all 1, ct_base=0 -> result_valid at cycle 14 after start, result=11.
REQ-033 PARALLEL=4, DIMENSION=10 -> 3 read beats, last beat's 4th lane zeroed, result matches software model over 100 random vectors.
REQ-034 result_ready held 0 for 20 cycles in HOLD -> result_valid and result stable; start pulses ignored; busy=1.
REQ-035 ct_base=250, ADDR_WIDTH=8 -> ct_addr sequence 250..255,0..4.
REQ-036 rst_n pulsed low at FETCH beat 5 -> immediate IDLE, no result_valid; next start gives a correct result.
REQ-037 DECRYPT_CTRL_ABORT_EN defined, abort in DRAIN -> IDLE next cycle, no result_valid; undefined build compiles without abort.

Source files
------------

// File: rtl/enclave_pkg.sv
// Shared definitions for the LWE decryption controller: FSM state encoding
// and the beat-count helper used to size the fetch loop.
package enclave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // A ciphertext has dimension+1 entries; round up to whole beats.
  function automatic int calc_beats(input int dimension, input int parallel);
    return (dimension + parallel) / parallel;
  endfunction

endpackage

// File: rtl/decrypt_ctrl_decrypt.sv
// Dot-product datapath: accumulates PARALLEL sk*ct products per enabled beat.
// Row 0 restarts the accumulator; the accumulator wraps mod 2^(2*CW+1).
module decrypt #(
  parameter int PARALLEL         = 1,
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int ROW_WIDTH        = 8,
  parameter int PLAINTEXT_WIDTH  = 6
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       en,
  input  logic [ROW_WIDTH-1:0]                       row,
  input  logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0]  sk,
  input  logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0]  ct,
  output logic [PLAINTEXT_WIDTH-1:0]                 dot
);

  localparam int ACC_WIDTH = 2 * CIPHERTEXT_WIDTH + 1;

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] beat_sum;

  // Sum of the lane products for the current beat.
  always_comb begin
    beat_sum = '0;
    for (int j = 0; j < PARALLEL; j++) begin
      beat_sum = beat_sum + (ACC_WIDTH'(sk[j]) * ACC_WIDTH'(ct[j]));
    end
  end

  // Accumulate on each enabled beat; row 0 starts a fresh dot product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= ((row == '0) ? '0 : acc) + beat_sum;
    end
  end

  assign dot = acc[PLAINTEXT_WIDTH-1:0];

endmodule

// File: rtl/decrypt_ctrl.sv
// LWE decryption controller: fetches secret-key and ciphertext words, feeds
// the dot-product datapath and holds the plaintext until it is accepted.
// Optional build macro DECRYPT_CTRL_ABORT_EN adds an abort input that drops
// an operation in FETCH or DRAIN without producing a result.
//
// state | meaning
// IDLE  | waiting for start, ct_base latched on start
// FETCH | one sk/ct read per cycle, k = 0..BEATS-1
// DRAIN | two cycles: last beat accumulates, then result settles
// HOLD  | result_valid high until result_ready
module decrypt_ctrl
  import enclave_pkg::*;
#(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int DIMENSION        = 10,
  parameter int PARALLEL         = 1,
  parameter int ADDR_WIDTH       = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [ADDR_WIDTH-1:0]                      ct_base,
`ifdef DECRYPT_CTRL_ABORT_EN
  input  logic                                       abort,
`endif
  output logic                                       busy,
  output logic [ADDR_WIDTH-1:0]                      sk_addr,
  output logic [ADDR_WIDTH-1:0]                      ct_addr,
  output logic                                       sk_rd,
  output logic                                       ct_rd,
  input  logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0]  sk_rdata,
  input  logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0]  ct_rdata,
  output logic                                       result_valid,
  input  logic                                       result_ready,
  output logic [PLAINTEXT_WIDTH-1:0]                 result
);

  localparam int BEATS = calc_beats(DIMENSION, PARALLEL);
  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(BEATS - 1);

  state_t                                     state;
  logic [ADDR_WIDTH-1:0]                      k;
  logic [ADDR_WIDTH-1:0]                      base;
  logic                                       drain_cnt;
  logic                                       en_d;
  logic [ADDR_WIDTH-1:0]                      row_d;
  logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0]  sk_m;
  logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0]  ct_m;
  logic [PLAINTEXT_WIDTH-1:0]                 dot;
  logic [PLAINTEXT_WIDTH-1:0]                 result_r;
  logic                                       abort_req;

`ifdef DECRYPT_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Sequencer: fetch loop, two-cycle drain, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      base      <= '0;
      drain_cnt <= 1'b0;
      result_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base  <= ct_base;
            k     <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (abort_req) begin
            k     <= '0;
            state <= IDLE;
          end else if (k == LAST_K) begin
            k         <= '0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (abort_req) begin
            drain_cnt <= 1'b0;
            state     <= IDLE;
          end else if (drain_cnt) begin
            drain_cnt <= 1'b0;
            result_r  <= dot;
            state     <= HOLD;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sk_rd   = (state == FETCH);
  assign ct_rd   = (state == FETCH);
  assign sk_addr = sk_rd ? k : '0;
  assign ct_addr = ct_rd ? (base + k) : '0;

  // Read data lands one cycle after the strobe, so enable and row follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d  <= 1'b0;
      row_d <= '0;
    end else begin
      en_d  <= sk_rd;
      row_d <= sk_addr;
    end
  end

  // Zero lanes past the last ciphertext entry in the final beat.
  always_comb begin
    sk_m = sk_rdata;
    ct_m = ct_rdata;
    for (int j = 0; j < PARALLEL; j++) begin
      if ((32'(row_d) * 32'(PARALLEL) + 32'(j)) > 32'(DIMENSION)) begin
        sk_m[j] = '0;
        ct_m[j] = '0;
      end
    end
  end

  decrypt #(
    .PARALLEL         (PARALLEL),
    .CIPHERTEXT_WIDTH (CIPHERTEXT_WIDTH),
    .ROW_WIDTH        (ADDR_WIDTH),
    .PLAINTEXT_WIDTH  (PLAINTEXT_WIDTH)
  ) u_decrypt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_d),
    .row   (row_d),
    .sk    (sk_m),
    .ct    (ct_m),
    .dot   (dot)
  );

  assign busy         = (state != IDLE);
  assign result_valid = (state == HOLD);
  assign result       = result_r;

endmodule

// File: tb/tb_decrypt_ctrl.sv
// Scoreboard bench for decrypt_ctrl: default instance plus a PARALLEL=4 one.
module tb_decrypt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, result_ready;
  logic [7:0] ct_base;
  logic busy, sk_rd, ct_rd, result_valid;
  logic [7:0] sk_addr, ct_addr;
  logic [0:0][9:0] sk_rdata, ct_rdata;
  logic [5:0] result;

  logic start_4, result_ready_4;
  logic [7:0] ct_base_4;
  logic busy_4, sk_rd_4, ct_rd_4, result_valid_4;
  logic [7:0] sk_addr_4, ct_addr_4;
  logic [3:0][9:0] sk_rdata_4, ct_rdata_4;
  logic [5:0] result_4;

`ifdef DECRYPT_CTRL_ABORT_EN
  logic abort;
`endif

  decrypt_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ct_base(ct_base),
`ifdef DECRYPT_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .sk_addr(sk_addr), .ct_addr(ct_addr), .sk_rd(sk_rd), .ct_rd(ct_rd),
    .sk_rdata(sk_rdata), .ct_rdata(ct_rdata), .result_valid(result_valid),
    .result_ready(result_ready), .result(result)
  );

  decrypt_ctrl #(.PARALLEL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_4), .ct_base(ct_base_4),
`ifdef DECRYPT_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_4), .sk_addr(sk_addr_4), .ct_addr(ct_addr_4), .sk_rd(sk_rd_4), .ct_rd(ct_rd_4),
    .sk_rdata(sk_rdata_4), .ct_rdata(ct_rdata_4), .result_valid(result_valid_4),
    .result_ready(result_ready_4), .result(result_4)
  );

  logic [9:0] skm [256];
  logic [9:0] ctm [256];
  logic [3:0][9:0] skm4 [256];
  logic [3:0][9:0] ctm4 [256];

  // Memory models: registered reads, data one cycle after the strobe.
  always @(posedge clk) begin
    if (sk_rd) sk_rdata[0] <= skm[sk_addr];
    if (ct_rd) ct_rdata[0] <= ctm[ct_addr];
    if (sk_rd_4) sk_rdata_4 <= skm4[sk_addr_4];
    if (ct_rd_4) ct_rdata_4 <= ctm4[ct_addr_4];
  end

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  int exp4_q[$];
  int ct_q[$];
  int k_q[$];
  int rd4_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop expectations whenever the DUTs present results or reads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result: got %0d expected none", result);
        end else check("result", 32'(result), exp_q.pop_front());
      end
      if (result_valid_4 && result_ready_4) begin
        if (exp4_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result4: got %0d expected none", result_4);
        end else check("result4", 32'(result_4), exp4_q.pop_front());
      end
      if (ct_rd) begin
        if (ct_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_read: got ct_addr %0d expected none", ct_addr);
        end else begin
          check("ct_addr", 32'(ct_addr), ct_q.pop_front());
          check("sk_addr", 32'(sk_addr), k_q.pop_front());
        end
      end
      if (ct_rd_4) rd4_cnt++;
    end
  end

  task automatic fill(input logic [9:0] skv, input logic [9:0] ctv);
    for (int a = 0; a < 256; a++) begin
      skm[a] = skv;
      ctm[a] = ctv;
    end
  endtask

  task automatic push_reads(input logic [7:0] base, input int nreads);
    for (int k = 0; k < nreads; k++) begin
      ct_q.push_back((int'(base) + k) % 256);
      k_q.push_back(k);
    end
  endtask

  // Called at posedge+1; returns one cycle after start is sampled.
  task automatic issue(input logic [7:0] base, input int exp);
    exp_q.push_back(exp);
    push_reads(base, 11);
    start = 1'b1;
    ct_base = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!result_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("valid_seen", 32'(result_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  task automatic quiet(input int ncyc, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (result_valid) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic op4();
    logic [7:0] base;
    logic [20:0] acc;
    int n;
    base = 8'($urandom_range(0, 255));
    for (int w = 0; w < 3; w++) begin
      for (int l = 0; l < 4; l++) begin
        skm4[w][l] = 10'($urandom);
        ctm4[(int'(base) + w) % 256][l] = 10'($urandom);
      end
    end
    acc = '0;
    for (int e = 0; e <= 10; e++) begin
      acc = acc + 21'(skm4[e / 4][e % 4]) * 21'(ctm4[(int'(base) + e / 4) % 256][e % 4]);
    end
    exp4_q.push_back(int'(acc[5:0]));
    rd4_cnt = 0;
    start_4 = 1'b1;
    ct_base_4 = base;
    @(posedge clk); #1;
    start_4 = 1'b0;
    n = 0;
    while ((busy_4 || n == 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle4", 32'(busy_4), 32'd0);
    check("beats4", 32'(rd4_cnt), 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; result_ready = 1'b1; ct_base = '0;
    start_4 = 1'b0; result_ready_4 = 1'b1; ct_base_4 = '0;
    sk_rdata = '0; ct_rdata = '0; sk_rdata_4 = '0; ct_rdata_4 = '0;
`ifdef DECRYPT_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    fill(10'd1, 10'd1);
    for (int a = 0; a < 256; a++) begin
      skm4[a] = '0;
      ctm4[a] = '0;
    end
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_sk_rd", 32'(sk_rd), 32'd0);
    check("rst_ct_rd", 32'(ct_rd), 32'd0);
    check("rst_sk_addr", 32'(sk_addr), 32'd0);
    check("rst_ct_addr", 32'(ct_addr), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // All ones: 11 entries of 1*1, result on cycle 14.
    issue(8'd0, 11);
    wait_valid(cyc);
    check("latency", 32'(cyc), 32'd14);
    wait_idle();

    // 11 * 3*5 = 165 -> 37 mod 64.
    fill(10'd3, 10'd5);
    issue(8'd0, 37);
    wait_idle();

    // 1023*1023 = 1 mod 64, times 11.
    fill(10'd1023, 10'd1023);
    issue(8'd0, 11);
    wait_idle();

    // Base 250 wraps to 0..4: 21*1 + 45*3 = 156 -> 28.
    fill(10'd0, 10'd1);
    for (int k = 0; k < 11; k++) skm[k] = 10'(k + 1);
    for (int a = 0; a < 5; a++) ctm[a] = 10'd3;
    ctm[5] = 10'd7;
    ctm[249] = 10'd7;
    issue(8'd250, 28);
    wait_idle();

    // Result held while not accepted; start ignored in HOLD.
    fill(10'd1, 10'd1);
    result_ready = 1'b0;
    issue(8'd0, 11);
    wait_valid(cyc);
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      ct_base = 8'd99;
      @(posedge clk); #1;
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_result", 32'(result), 32'd11);
      check("hold_busy", 32'(busy), 32'd1);
    end
    start = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("start_ignored", 32'(busy), 32'd0);

    // Reset during FETCH beat 5 discards the operation.
    push_reads(8'd0, 5);
    start = 1'b1;
    ct_base = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("beat5_addr", 32'(sk_addr), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rd", 32'(sk_rd), 32'd0);
    check("rst_mid_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    quiet(20, "rst_no_valid");
    issue(8'd0, 11);
    wait_idle();

`ifdef DECRYPT_CTRL_ABORT_EN
    // Abort in the first DRAIN cycle.
    push_reads(8'd0, 11);
    start = 1'b1;
    ct_base = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
    end
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_rd", 32'(sk_rd), 32'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    quiet(20, "abort_no_valid");
    issue(8'd0, 11);
    wait_idle();
`endif

    // PARALLEL=4: random vectors against the software model.
    for (int v = 0; v < 100; v++) op4();

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp4_q_empty", 32'(exp4_q.size()), 32'd0);
    check("ct_q_empty", 32'(ct_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
